link_train_monitor: RTL
=======================

LINK_TRAIN_MONITOR -- requirements
Module: link_train_monitor

Interface
REQ-001 The parameters SHALL be:
- TIMEOUT_CYCLES, default 12_500_000; training timeout in pclk cycles (100 ms at 125 MHz).
- RESTART_CYCLES, default 1_250; LTSSM-disable hold time before retrain.
- STABLE_CYCLES, default 1_250; consecutive link_up cycles required to declare link OK.
- MAX_RETRIES, default 7; retrains allowed before failure.

REQ-002 The ports SHALL be (reset perst_n, asynchronous, active-low; clock pclk):
- pclk  in  1  125 MHz PIPE clock.
- perst_n  in  1  asynchronous active-low reset.
- ltssm_en_in  in  1  delayed LTSSM enable from the PERST# enable timer.
- link_up  in  1  link-up status from the PCIe core (pclk domain).
- ltssm_enable_out  out  1  LTSSM enable driven to the PCIe core.
- link_ok  out  1  link stable and up.
- train_fail  out  1  sticky failure after the retry budget is exhausted.
- restart_pulse  out  1  one-cycle pulse per retrain.
- retry_cnt  out  RW=$clog2(MAX_RETRIES+1)  retrains performed since the last IDLE or UP exit.

Function
REQ-003 All outputs SHALL be registered and SHALL reflect the state entered on the same clock edge.
REQ-004 The FSM SHALL have exactly six states: IDLE, TRAIN, STABLE, UP, RESTART, FAIL.
REQ-005 If ltssm_en_in is sampled 0 in any state, the FSM SHALL go to IDLE and clear the timers and retry_cnt. This rule has priority over all other transitions.
REQ-006 In IDLE, when ltssm_en_in=1, the FSM SHALL go to TRAIN and clear the training timer.
REQ-007 In TRAIN and STABLE, the training timer SHALL increment by 1 per cycle and SHALL NOT wrap.
REQ-008 In TRAIN, link_up=1 SHALL cause STABLE with the stable counter cleared. If link_up=1 and a timeout occur in the same cycle, link_up wins.
REQ-009 In STABLE, link_up=0 SHALL return the FSM to TRAIN without clearing the training timer.
REQ-010 In STABLE, once link_up has been 1 for STABLE_CYCLES consecutive cycles, the FSM SHALL go to UP.
REQ-011 A timeout SHALL occur when the training timer equals TIMEOUT_CYCLES-1 in TRAIN or STABLE.
- If retry_cnt < MAX_RETRIES: go to RESTART, increment retry_cnt, assert restart_pulse for 1 cycle.
- Otherwise: go to FAIL.
REQ-012 RESTART SHALL last exactly RESTART_CYCLES cycles, then go to TRAIN with the training timer cleared.
REQ-013 In UP, link_up=0 SHALL cause TRAIN with the training timer and retry_cnt cleared.
REQ-014 FAIL SHALL be terminal and exit only via REQ-005 or reset.
REQ-015 Output decode per state SHALL be:

| Output | Asserted in |
|---|---|
| ltssm_enable_out | TRAIN, STABLE, UP |
| link_ok | UP only |
| train_fail | FAIL only |

- retry_cnt saturates at MAX_RETRIES.

Reset
REQ-016 While perst_n=0, the block SHALL be in IDLE, all counters SHALL be 0, and all outputs SHALL be 0. Assertion SHALL take effect asynchronously at any point, including mid-RESTART.
REQ-017 After perst_n deasserts, the first transition SHALL occur no earlier than the first pclk edge at which ltssm_en_in=1.

Configuration
REQ-018 When the macro LINK_TRAIN_MON_DBG_EN is defined, the block SHALL add the following ports:
- ltssm_state  in  6
- fail_ltssm_state  out  6: latched from ltssm_state on every timeout (REQ-011); reset 0; cleared on IDLE entry.
- timeout_cnt  out  8: saturating total of timeouts; cleared only by perst_n.

REQ-019 When LINK_TRAIN_MON_DBG_EN is undefined, these ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
Test parameters: TIMEOUT_CYCLES=100, RESTART_CYCLES=10, STABLE_CYCLES=8, MAX_RETRIES=2.

REQ-020 Nominal: ltssm_en_in=1, then link_up=1 at cycle 20 and held -> ltssm_enable_out=1 from cycle 1; link_ok=1 at cycle 28; retry_cnt=0.
REQ-021 Retry then pass: link_up held 0 -> restart_pulse at cycle 100 and ltssm_enable_out=0 for 10 cycles; link_up=1 in the second window -> link_ok=1; retry_cnt=1.
REQ-022 Exhaustion: link_up held 0 -> 2 restart pulses, then train_fail=1 and ltssm_enable_out=0 sticky; ltssm_en_in pulsed low -> IDLE, then TRAIN with retry_cnt=0.
REQ-023 Glitch: link_up high for 5 cycles then low in STABLE -> no link_ok; timer not reset, so timeout at the original cycle 100.
REQ-024 Link drop and reset: in UP, link_up=0 -> link_ok=0 next cycle and TRAIN with the timer at 0. perst_n asserted mid-RESTART -> all outputs 0 immediately.
REQ-025 Tie and debug: timeout and link_up rise in the same cycle -> STABLE, no restart_pulse. With DBG_EN, ltssm_state=0x11 at timeout -> fail_ltssm_state=0x11 and timeout_cnt=1.

Source files
------------

// File: rtl/link_train_monitor.sv
// link_train_monitor
// PCIe link-training watchdog. Enables the LTSSM, waits for link-up to hold
// steady, and retrains when training times out. The link is declared failed
// after MAX_RETRIES retrains.
// Optional debug ports are enabled by defining LINK_TRAIN_MON_DBG_EN.
module link_train_monitor #(
    parameter int TIMEOUT_CYCLES = 12_500_000,
    parameter int RESTART_CYCLES = 1_250,
    parameter int STABLE_CYCLES  = 1_250,
    parameter int MAX_RETRIES    = 7
) (
    input  logic                               pclk,
    input  logic                               perst_n,
    input  logic                               ltssm_en_in,
    input  logic                               link_up,
    output logic                               ltssm_enable_out,
    output logic                               link_ok,
    output logic                               train_fail,
    output logic                               restart_pulse,
`ifdef LINK_TRAIN_MON_DBG_EN
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    input  logic [5:0]                         ltssm_state,
    output logic [5:0]                         fail_ltssm_state,
    output logic [7:0]                         timeout_cnt
`else
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
`endif
);

    localparam int RW     = $clog2(MAX_RETRIES + 1);
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int CW_RAW = (RESTART_CYCLES > STABLE_CYCLES) ? $clog2(RESTART_CYCLES)
                                                             : $clog2(STABLE_CYCLES);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RESTART_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRAIN   = 3'd1;
    localparam logic [2:0] S_STABLE  = 3'd2;
    localparam logic [2:0] S_UP      = 3'd3;
    localparam logic [2:0] S_RESTART = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic [TW-1:0] tmr_inc;
    logic [CW-1:0] cnt;       // stable run length in STABLE, hold count in RESTART
    logic [CW-1:0] cnt_nxt;
    logic [RW-1:0] retry_nxt;
    logic          timeout_evt;

    // Next-state, timer and retry decisions; disable has priority over everything.
    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        cnt_nxt     = cnt;
        retry_nxt   = retry_cnt;
        timeout_evt = 1'b0;
        // The training timer parks at its last value instead of wrapping, so a
        // timeout that was deferred by a link-up tie still fires on the next cycle.
        tmr_inc     = (tmr == TMR_LAST) ? tmr : tmr + 1'b1;

        if (!ltssm_en_in) begin
            state_nxt = S_IDLE;
            tmr_nxt   = '0;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_TRAIN;
                    tmr_nxt   = '0;
                end
                S_TRAIN: begin
                    tmr_nxt = tmr_inc;
                    if (link_up) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (tmr == TMR_LAST) begin
                        timeout_evt = 1'b1;
                    end
                end
                S_STABLE: begin
                    tmr_nxt = tmr_inc;
                    if (link_up && (cnt == STB_LAST)) begin
                        state_nxt = S_UP;
                    end else if (tmr == TMR_LAST) begin
                        timeout_evt = 1'b1;
                    end else if (!link_up) begin
                        state_nxt = S_TRAIN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_UP: begin
                    if (!link_up) begin
                        state_nxt = S_TRAIN;
                        tmr_nxt   = '0;
                        retry_nxt = '0;
                    end
                end
                S_RESTART: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_TRAIN;
                        tmr_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase

            if (timeout_evt) begin
                if (retry_cnt < RETRY_MAX) begin
                    state_nxt = S_RESTART;
                    cnt_nxt   = '0;
                    retry_nxt = retry_cnt + 1'b1;
                end else begin
                    state_nxt = S_FAIL;
                end
            end
        end
    end

    // State, counters and outputs; outputs decode the state being entered.
    always_ff @(posedge pclk or negedge perst_n) begin
        if (!perst_n) begin
            state            <= S_IDLE;
            tmr              <= '0;
            cnt              <= '0;
            retry_cnt        <= '0;
            ltssm_enable_out <= 1'b0;
            link_ok          <= 1'b0;
            train_fail       <= 1'b0;
            restart_pulse    <= 1'b0;
        end else begin
            state            <= state_nxt;
            tmr              <= tmr_nxt;
            cnt              <= cnt_nxt;
            retry_cnt        <= retry_nxt;
            ltssm_enable_out <= (state_nxt == S_TRAIN) || (state_nxt == S_STABLE) ||
                                (state_nxt == S_UP);
            link_ok          <= (state_nxt == S_UP);
            train_fail       <= (state_nxt == S_FAIL);
            restart_pulse    <= (state_nxt == S_RESTART) && (state != S_RESTART);
        end
    end

`ifdef LINK_TRAIN_MON_DBG_EN
    // Capture the LTSSM state at each timeout and keep a running timeout total.
    always_ff @(posedge pclk or negedge perst_n) begin
        if (!perst_n) begin
            fail_ltssm_state <= '0;
            timeout_cnt      <= '0;
        end else begin
            if (state_nxt == S_IDLE) begin
                fail_ltssm_state <= '0;
            end else if (timeout_evt) begin
                fail_ltssm_state <= ltssm_state;
            end
            if (timeout_evt && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
